// File: rtl/di_arb_pkg.sv
// ----------------------------------------------------------------------------
// di_arb_pkg
// Shared definitions for the two-master di register-bus arbiter: arbiter
// state encoding, master count and di bus width.
// ----------------------------------------------------------------------------
package di_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int DI_W        = 16;

    // IDLE arbitrates, OWNn forwards master n, GAP is the dead cycle
    // inserted after every release before the next arbitration.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2,
        ST_GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/di_arb_fsm.sv
// ----------------------------------------------------------------------------
// di_arb_fsm
// Ownership state machine for di_arbiter: state register, last-served bit
// and hold counter.
//
// Ports:
//   ifclk         in   clock, rising edge
//   resetb        in   asynchronous active-low reset
//   i_req[1:0]    in   bus requests, bit n = master n
//   o_gnt[1:0]    out  registered one-hot grant (or 0)
//   o_hold_reach  out  high in the cycle whose closing edge brings the hold
//                      counter to HOLD_MAX
// ----------------------------------------------------------------------------
module di_arb_fsm
    import di_arb_pkg::*;
#(
    parameter int HOLD_MAX = 1024,
    parameter int HOLD_W   = 11
) (
    input  logic                   ifclk,
    input  logic                   resetb,
    input  logic [NUM_MASTERS-1:0] i_req,
    output logic [NUM_MASTERS-1:0] o_gnt,
    output logic                   o_hold_reach
);

    localparam logic [HOLD_W-1:0] HOLD_MAX_C = HOLD_W'(HOLD_MAX);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

    arb_state_t             r_state;
    logic                   r_last;
    logic [HOLD_W-1:0]      r_cnt;
    logic [NUM_MASTERS-1:0] r_gnt;
    logic                   w_contend;

    // An owner whose own request has dropped leaves for GAP this edge, so
    // "both requesting while owning" is exactly "owner holds, other waits".
    assign w_contend    = ((r_state == ST_OWN0) || (r_state == ST_OWN1)) && (&i_req);
    assign o_hold_reach = w_contend && (r_cnt == (HOLD_MAX_C - HOLD_ONE));
    assign o_gnt        = r_gnt;

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_gnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // On a tie the master not served last wins.
                    if (i_req[0] && (!i_req[1] || r_last)) begin
                        r_state <= ST_OWN0;
                        r_gnt   <= 2'b01;
                        r_cnt   <= '0;
                    end else if (i_req[1]) begin
                        r_state <= ST_OWN1;
                        r_gnt   <= 2'b10;
                        r_cnt   <= '0;
                    end
                end
                ST_OWN0: begin
                    // last is taken on GAP entry; GAP always precedes IDLE,
                    // so arbitration sees the same value.
                    if (!i_req[0]) begin
                        r_state <= ST_GAP;
                        r_gnt   <= '0;
                        r_last  <= 1'b0;
                    end else if (w_contend && (r_cnt != HOLD_MAX_C)) begin
                        r_cnt <= r_cnt + HOLD_ONE;
                    end
                end
                ST_OWN1: begin
                    if (!i_req[1]) begin
                        r_state <= ST_GAP;
                        r_gnt   <= '0;
                        r_last  <= 1'b1;
                    end else if (w_contend && (r_cnt != HOLD_MAX_C)) begin
                        r_cnt <= r_cnt + HOLD_ONE;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/di_arbiter.sv
// ----------------------------------------------------------------------------
// di_arbiter
// Two-master arbiter for the di register bus. Master 0 is the FX2 bridge,
// master 1 the on-chip local master. One owner at a time, a dead cycle
// between owners, non-owner strobes dropped and flagged.
//
// Ports:
//   ifclk, resetb                       clock / async active-low reset
//   mN_req                              request, held for the transaction
//   mN_gnt                              registered grant
//   mN_term_addr/reg_addr/reg_datai     master address and write data
//   mN_read, mN_write                   strobes, honoured only when granted
//   mN_read_rdy, mN_write_rdy           slave readies, owner only
//   mN_reg_datao                        slave read data, to both masters
//   di_term_addr/reg_addr/reg_datai     owner's values, held when idle
//   di_read, di_write                   owner's strobes, 0 without owner
//   di_read_rdy, di_write_rdy           slave readies
//   di_reg_datao                        slave read data
//   hold_err                            sticky: owner held past HOLD_MAX
//   ungnt_err[1:0]                      sticky: strobe without grant
// ----------------------------------------------------------------------------
module di_arbiter
    import di_arb_pkg::*;
#(
    parameter int HOLD_MAX = 1024,
    parameter int HOLD_W   = 11
) (
    input  logic                   ifclk,
    input  logic                   resetb,

    input  logic                   m0_req,
    output logic                   m0_gnt,
    input  logic [DI_W-1:0]        m0_term_addr,
    input  logic [DI_W-1:0]        m0_reg_addr,
    input  logic [DI_W-1:0]        m0_reg_datai,
    input  logic                   m0_read,
    input  logic                   m0_write,
    output logic                   m0_read_rdy,
    output logic                   m0_write_rdy,
    output logic [DI_W-1:0]        m0_reg_datao,

    input  logic                   m1_req,
    output logic                   m1_gnt,
    input  logic [DI_W-1:0]        m1_term_addr,
    input  logic [DI_W-1:0]        m1_reg_addr,
    input  logic [DI_W-1:0]        m1_reg_datai,
    input  logic                   m1_read,
    input  logic                   m1_write,
    output logic                   m1_read_rdy,
    output logic                   m1_write_rdy,
    output logic [DI_W-1:0]        m1_reg_datao,

    output logic [DI_W-1:0]        di_term_addr,
    output logic [DI_W-1:0]        di_reg_addr,
    output logic [DI_W-1:0]        di_reg_datai,
    output logic                   di_read,
    output logic                   di_write,
    input  logic                   di_read_rdy,
    input  logic                   di_write_rdy,
    input  logic [DI_W-1:0]        di_reg_datao,

    output logic                   hold_err,
    output logic [NUM_MASTERS-1:0] ungnt_err
);

    logic [NUM_MASTERS-1:0] w_gnt;
    logic                   w_hold_reach;
    logic [DI_W-1:0]        w_term_addr;
    logic [DI_W-1:0]        w_reg_addr;
    logic [DI_W-1:0]        w_reg_datai;
    logic [NUM_MASTERS-1:0] w_strobe;

    logic [DI_W-1:0]        r_hold_term_addr;
    logic [DI_W-1:0]        r_hold_reg_addr;
    logic [DI_W-1:0]        r_hold_reg_datai;
    logic                   r_hold_err;
    logic [NUM_MASTERS-1:0] r_ungnt_err;

    di_arb_fsm #(
        .HOLD_MAX (HOLD_MAX),
        .HOLD_W   (HOLD_W)
    ) u_fsm (
        .ifclk        (ifclk),
        .resetb       (resetb),
        .i_req        ({m1_req, m0_req}),
        .o_gnt        (w_gnt),
        .o_hold_reach (w_hold_reach)
    );

    assign m0_gnt = w_gnt[0];
    assign m1_gnt = w_gnt[1];

    // Owner's address/data pass straight through; with no owner the bus
    // shows the values from the last owned cycle.
    always_comb begin
        w_term_addr = r_hold_term_addr;
        w_reg_addr  = r_hold_reg_addr;
        w_reg_datai = r_hold_reg_datai;
        if (w_gnt[0]) begin
            w_term_addr = m0_term_addr;
            w_reg_addr  = m0_reg_addr;
            w_reg_datai = m0_reg_datai;
        end else if (w_gnt[1]) begin
            w_term_addr = m1_term_addr;
            w_reg_addr  = m1_reg_addr;
            w_reg_datai = m1_reg_datai;
        end
    end

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_hold_term_addr <= '0;
            r_hold_reg_addr  <= '0;
            r_hold_reg_datai <= '0;
        end else if (|w_gnt) begin
            r_hold_term_addr <= w_term_addr;
            r_hold_reg_addr  <= w_reg_addr;
            r_hold_reg_datai <= w_reg_datai;
        end
    end

    assign di_term_addr = w_term_addr;
    assign di_reg_addr  = w_reg_addr;
    assign di_reg_datai = w_reg_datai;

    assign di_read  = (w_gnt[0] & m0_read)  | (w_gnt[1] & m1_read);
    assign di_write = (w_gnt[0] & m0_write) | (w_gnt[1] & m1_write);

    assign m0_read_rdy  = w_gnt[0] & di_read_rdy;
    assign m0_write_rdy = w_gnt[0] & di_write_rdy;
    assign m1_read_rdy  = w_gnt[1] & di_read_rdy;
    assign m1_write_rdy = w_gnt[1] & di_write_rdy;

    assign m0_reg_datao = di_reg_datao;
    assign m1_reg_datao = di_reg_datao;

    assign w_strobe = {m1_read | m1_write, m0_read | m0_write};

    always_ff @(posedge ifclk or negedge resetb) begin
        if (!resetb) begin
            r_hold_err  <= 1'b0;
            r_ungnt_err <= '0;
        end else begin
            if (w_hold_reach) begin
                r_hold_err <= 1'b1;
            end
            r_ungnt_err <= r_ungnt_err | (w_strobe & ~w_gnt);
        end
    end

    assign hold_err  = r_hold_err;
    assign ungnt_err = r_ungnt_err;

endmodule

// File: tb/tb_di_arbiter.sv
module tb_di_arbiter;

    logic        ifclk = 1'b0;
    logic        resetb;
    logic        m0_req, m1_req;
    logic        m0_gnt, m1_gnt;
    logic [15:0] m0_term_addr, m0_reg_addr, m0_reg_datai;
    logic [15:0] m1_term_addr, m1_reg_addr, m1_reg_datai;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic        m0_read_rdy, m0_write_rdy, m1_read_rdy, m1_write_rdy;
    logic [15:0] m0_reg_datao, m1_reg_datao;
    logic [15:0] di_term_addr, di_reg_addr, di_reg_datai;
    logic        di_read, di_write;
    logic        di_read_rdy, di_write_rdy;
    logic [15:0] di_reg_datao;
    logic        hold_err;
    logic [1:0]  ungnt_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 ifclk = ~ifclk;

    di_arbiter #(.HOLD_MAX(1024), .HOLD_W(11)) dut (
        .ifclk        (ifclk),
        .resetb       (resetb),
        .m0_req       (m0_req),
        .m0_gnt       (m0_gnt),
        .m0_term_addr (m0_term_addr),
        .m0_reg_addr  (m0_reg_addr),
        .m0_reg_datai (m0_reg_datai),
        .m0_read      (m0_read),
        .m0_write     (m0_write),
        .m0_read_rdy  (m0_read_rdy),
        .m0_write_rdy (m0_write_rdy),
        .m0_reg_datao (m0_reg_datao),
        .m1_req       (m1_req),
        .m1_gnt       (m1_gnt),
        .m1_term_addr (m1_term_addr),
        .m1_reg_addr  (m1_reg_addr),
        .m1_reg_datai (m1_reg_datai),
        .m1_read      (m1_read),
        .m1_write     (m1_write),
        .m1_read_rdy  (m1_read_rdy),
        .m1_write_rdy (m1_write_rdy),
        .m1_reg_datao (m1_reg_datao),
        .di_term_addr (di_term_addr),
        .di_reg_addr  (di_reg_addr),
        .di_reg_datai (di_reg_datai),
        .di_read      (di_read),
        .di_write     (di_write),
        .di_read_rdy  (di_read_rdy),
        .di_write_rdy (di_write_rdy),
        .di_reg_datao (di_reg_datao),
        .hold_err     (hold_err),
        .ungnt_err    (ungnt_err)
    );

    typedef struct {
        logic        own1;
        logic [15:0] m0_ta, m0_ra, m0_wd;
        logic [15:0] m1_ta, m1_ra, m1_wd;
        logic [3:0]  strb;   // {m1_write, m1_read, m0_write, m0_read}
        logic [1:0]  rdy;    // {di_write_rdy, di_read_rdy}
        logic [15:0] sdat;
        logic [15:0] e_ta, e_ra, e_wd;
        logic        e_rd, e_wr;
        logic [3:0]  e_rdy;  // {m1_write_rdy, m1_read_rdy, m0_write_rdy, m0_read_rdy}
    } vec_t;

    vec_t vecs[7];
    vec_t exp_q[$];

    function automatic vec_t mk(
        input logic own1,
        input logic [15:0] m0_ta, m0_ra, m0_wd, m1_ta, m1_ra, m1_wd,
        input logic [3:0] strb, input logic [1:0] rdy, input logic [15:0] sdat,
        input logic [15:0] e_ta, e_ra, e_wd,
        input logic e_rd, e_wr, input logic [3:0] e_rdy);
        vec_t v;
        v.own1 = own1;
        v.m0_ta = m0_ta; v.m0_ra = m0_ra; v.m0_wd = m0_wd;
        v.m1_ta = m1_ta; v.m1_ra = m1_ra; v.m1_wd = m1_wd;
        v.strb = strb; v.rdy = rdy; v.sdat = sdat;
        v.e_ta = e_ta; v.e_ra = e_ra; v.e_wd = e_wd;
        v.e_rd = e_rd; v.e_wr = e_wr; v.e_rdy = e_rdy;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge ifclk);
        #1;
    endtask

    task automatic clear_strobes();
        m0_read = 1'b0; m0_write = 1'b0; m1_read = 1'b0; m1_write = 1'b0;
    endtask

    // Release the bus, then request it for master n only, waiting a bounded time.
    task automatic acquire(input int n);
        bit got;
        clear_strobes();
        m0_req = 1'b0;
        m1_req = 1'b0;
        step();
        step();
        if (n == 0) m0_req = 1'b1; else m1_req = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            got = (n == 0) ? m0_gnt : m1_gnt;
        end
        chk($sformatf("acquire_m%0d", n), {15'd0, got}, 16'd1);
    endtask

    initial begin
        vec_t v;
        vec_t e;
        int   cur_own;
        bit   got;

        vecs[0] = mk(0, 16'h0003, 16'h0010, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333,
                     4'b0010, 2'b10, 16'h1234, 16'h0003, 16'h0010, 16'hBEEF, 0, 1, 4'b0010);
        vecs[1] = mk(0, 16'h0003, 16'h0010, 16'hBEEF, 16'h1111, 16'h2222, 16'h3333,
                     4'b0010, 2'b00, 16'h1234, 16'h0003, 16'h0010, 16'hBEEF, 0, 1, 4'b0000);
        vecs[2] = mk(0, 16'h00A5, 16'h0001, 16'h0000, 16'h1111, 16'h2222, 16'h3333,
                     4'b0001, 2'b01, 16'h5A5A, 16'h00A5, 16'h0001, 16'h0000, 1, 0, 4'b0001);
        vecs[3] = mk(0, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1111, 16'h2222, 16'h3333,
                     4'b0000, 2'b11, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 0, 0, 4'b0011);
        vecs[4] = mk(1, 16'h3333, 16'h4444, 16'h5555, 16'h0002, 16'h0020, 16'hCAFE,
                     4'b0100, 2'b01, 16'h0F0F, 16'h0002, 16'h0020, 16'hCAFE, 1, 0, 4'b0100);
        vecs[5] = mk(1, 16'h3333, 16'h4444, 16'h5555, 16'h0002, 16'h0021, 16'hD00D,
                     4'b1000, 2'b11, 16'h0000, 16'h0002, 16'h0021, 16'hD00D, 0, 1, 4'b1100);
        vecs[6] = mk(1, 16'h3333, 16'h4444, 16'h5555, 16'h0C0D, 16'hFFFF, 16'h0001,
                     4'b1100, 2'b10, 16'h8001, 16'h0C0D, 16'hFFFF, 16'h0001, 1, 1, 4'b1000);

        // Reset state, with busy-looking inputs.
        resetb = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        clear_strobes();
        m0_term_addr = 16'hAAAA; m0_reg_addr = 16'hBBBB; m0_reg_datai = 16'hCCCC;
        m1_term_addr = 16'h1111; m1_reg_addr = 16'h2222; m1_reg_datai = 16'h3333;
        di_read_rdy = 1'b1; di_write_rdy = 1'b1; di_reg_datao = 16'h0000;
        #2;
        chk("rst_gnt", {14'd0, m1_gnt, m0_gnt}, 16'd0);
        chk("rst_di_term", di_term_addr, 16'h0000);
        chk("rst_di_reg", di_reg_addr, 16'h0000);
        chk("rst_di_dat", di_reg_datai, 16'h0000);
        chk("rst_rdy", {12'd0, m1_write_rdy, m1_read_rdy, m0_write_rdy, m0_read_rdy}, 16'd0);
        chk("rst_err", {13'd0, hold_err, ungnt_err}, 16'd0);
        step();
        step();
        resetb = 1'b1;

        // First tie after reset goes to master 0; then m1 after GAP+IDLE; then m0 again.
        step();
        chk("tie0_gnt", {14'd0, m1_gnt, m0_gnt}, 16'b01);
        m0_req = 1'b0;
        step();
        chk("rel_gap_gnt", {14'd0, m1_gnt, m0_gnt}, 16'b00);
        step();
        chk("rel_idle_gnt", {14'd0, m1_gnt, m0_gnt}, 16'b00);
        step();
        chk("tie0_then_m1", {14'd0, m1_gnt, m0_gnt}, 16'b10);
        m0_req = 1'b1;
        m1_req = 1'b0;
        step();
        chk("m1_rel_gap", {14'd0, m1_gnt, m0_gnt}, 16'b00);
        m1_req = 1'b1;
        step();
        step();
        chk("tie1_gnt", {14'd0, m1_gnt, m0_gnt}, 16'b01);

        // Table-driven forwarding checks through the scoreboard.
        cur_own = 2;
        for (int i = 0; i < 7; i++) begin
            v = vecs[i];
            if (int'(v.own1) != cur_own) begin
                acquire(int'(v.own1));
                cur_own = int'(v.own1);
            end
            m0_term_addr = v.m0_ta; m0_reg_addr = v.m0_ra; m0_reg_datai = v.m0_wd;
            m1_term_addr = v.m1_ta; m1_reg_addr = v.m1_ra; m1_reg_datai = v.m1_wd;
            {m1_write, m1_read, m0_write, m0_read} = v.strb;
            {di_write_rdy, di_read_rdy} = v.rdy;
            di_reg_datao = v.sdat;
            exp_q.push_back(v);
            #1;
            e = exp_q.pop_front();
            chk($sformatf("v%0d_term", i), di_term_addr, e.e_ta);
            chk($sformatf("v%0d_reg", i), di_reg_addr, e.e_ra);
            chk($sformatf("v%0d_dati", i), di_reg_datai, e.e_wd);
            chk($sformatf("v%0d_strb", i), {14'd0, di_read, di_write}, {14'd0, e.e_rd, e.e_wr});
            chk($sformatf("v%0d_rdy", i),
                {12'd0, m1_write_rdy, m1_read_rdy, m0_write_rdy, m0_read_rdy}, {12'd0, e.e_rdy});
            chk($sformatf("v%0d_dato0", i), m0_reg_datao, e.sdat);
            chk($sformatf("v%0d_dato1", i), m1_reg_datao, e.sdat);
            step();
        end
        chk("table_ungnt", {14'd0, ungnt_err}, 16'd0);

        // Idle bus holds the last owner's address.
        m1_req = 1'b0;
        clear_strobes();
        step();
        m1_term_addr = 16'h9999;
        #1;
        chk("gap_hold_term", di_term_addr, 16'h0C0D);
        chk("gap_strb", {14'd0, di_read, di_write}, 16'd0);

        // Non-owner strobe is masked and flagged.
        acquire(0);
        di_read_rdy = 1'b1;
        m1_read = 1'b1;
        #1;
        chk("ungnt_di_read", {15'd0, di_read}, 16'd0);
        chk("ungnt_m1_rdy", {15'd0, m1_read_rdy}, 16'd0);
        step();
        m1_read = 1'b0;
        chk("ungnt_set", {14'd0, ungnt_err}, 16'b10);
        step();
        step();
        chk("ungnt_sticky", {14'd0, ungnt_err}, 16'b10);

        // Asynchronous reset while m1 owns mid-read.
        m0_req = 1'b0;
        acquire(1);
        m1_read = 1'b1;
        di_read_rdy = 1'b1;
        #1;
        chk("m1_read_fwd", {14'd0, di_read, m1_read_rdy}, 16'b11);
        #2;
        resetb = 1'b0;
        #1;
        chk("arst_gnt", {14'd0, m1_gnt, m0_gnt}, 16'd0);
        chk("arst_strb", {13'd0, di_read, di_write, m1_read_rdy}, 16'd0);
        chk("arst_err", {13'd0, hold_err, ungnt_err}, 16'd0);
        chk("arst_term", di_term_addr, 16'h0000);
        m1_read = 1'b0;
        m0_req = 1'b1;
        step();
        resetb = 1'b1;
        step();
        chk("arst_tie_m0", {14'd0, m1_gnt, m0_gnt}, 16'b01);

        // Back-to-back m0 transactions with m1 idle.
        m1_req = 1'b0;
        m0_term_addr = 16'h0042;
        m0_write = 1'b1;
        step();
        chk("b2b_wr", {15'd0, di_write}, 16'd1);
        m0_req = 1'b0;
        #1;
        chk("b2b_fall_wr", {14'd0, m0_gnt, di_write}, 16'b11);
        step();
        m0_req = 1'b1;
        m0_term_addr = 16'h0043;
        #1;
        chk("b2b_gap_gnt", {15'd0, m0_gnt}, 16'd0);
        chk("b2b_gap_wr", {15'd0, di_write}, 16'd0);
        chk("b2b_gap_term", di_term_addr, 16'h0042);
        step();
        m0_write = 1'b0;
        chk("b2b_idle_gnt", {15'd0, m0_gnt}, 16'd0);
        chk("b2b_ungnt0", {14'd0, ungnt_err}, 16'b01);
        step();
        chk("b2b_regnt", {15'd0, m0_gnt}, 16'd1);
        chk("b2b_term", di_term_addr, 16'h0043);

        // Hold limit: m0 keeps the bus while m1 waits.
        m0_req = 1'b0;
        resetb = 1'b0;
        #1;
        chk("rst2_err", {13'd0, hold_err, ungnt_err}, 16'd0);
        m0_req = 1'b1;
        step();
        resetb = 1'b1;
        step();
        chk("hold_own", {14'd0, m1_gnt, m0_gnt}, 16'b01);
        m1_req = 1'b1;
        repeat (1023) step();
        chk("hold_1023", {14'd0, hold_err, m0_gnt}, 16'b01);
        step();
        chk("hold_1024", {13'd0, hold_err, m1_gnt, m0_gnt}, 16'b101);
        repeat (5) step();
        chk("hold_sticky", {13'd0, hold_err, m1_gnt, m0_gnt}, 16'b101);
        m0_req = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            step();
            got = m1_gnt;
        end
        chk("hold_m1_gnt", {15'd0, got}, 16'd1);
        chk("hold_kept", {15'd0, hold_err}, 16'd1);

        chk("sb_empty", 16'(exp_q.size()), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
